// File: rtl/riscv_mem_pkg.sv
// Shared encodings and records for the unified-memory front end of the RV32I core.
package riscv_mem_pkg;

  // Arbiter FSM encoding, kept as plain constants so older blocks can reuse it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Which requester owns the transaction currently on the memory bus.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // One byte-enable bit per byte lane.
  function automatic int beWidth(input int dataW);
    return dataW / 8;
  endfunction

  // Store-request record as seen by the data-memory modules.
  typedef struct packed {
    logic                    we;
    logic [DEF_DATA_W/8-1:0] be;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
  } storeReq_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory arbiter: data beats fetch, except that fetch is
// forced once it has watched STARVE_MAX data grants in a row.
module mem_arb_prio
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic arbEn,
  output logic grant_if,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starveCnt;
  logic             starveHit;

  // Combinational winner: only one grant can ever be high.
  always_comb begin
    starveHit = if_req && (starveCnt == CNT_W'(STARVE_MAX));
    grant_d   = arbEn && d_req && !starveHit;
    grant_if  = arbEn && if_req && !grant_d;
  end

  // Count data grants that fetch had to sit through; any idle fetch cycle or
  // fetch grant forgives the debt.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (!if_req || grant_if) begin
      starveCnt <= '0;
    end else if (grant_d && (starveCnt != CNT_W'(STARVE_MAX))) begin
      starveCnt <= starveCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and load/store, one transaction at a time, routing each response back to
// the port that issued it.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate any pending request
//   ST_ISSUE | m_req high with latched fields until the memory takes it
//   ST_WAIT  | waiting for m_rvalid; re-arbitrate in the response cycle
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req,
  input  logic [ADDR_W-1:0]           if_addr,
  output logic                        if_gnt,
  output logic                        if_rvalid,
  output logic [DATA_W-1:0]           if_rdata,
  input  logic                        d_req,
  input  logic                        d_we,
  input  logic [beWidth(DATA_W)-1:0]  d_be,
  input  logic [ADDR_W-1:0]           d_addr,
  input  logic [DATA_W-1:0]           d_wdata,
  output logic                        d_gnt,
  output logic                        d_rvalid,
  output logic [DATA_W-1:0]           d_rdata,
  output logic                        m_req,
  output logic                        m_we,
  output logic [beWidth(DATA_W)-1:0]  m_be,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  input  logic                        m_gnt,
  input  logic                        m_rvalid,
  input  logic [DATA_W-1:0]           m_rdata,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int BE_W = beWidth(DATA_W);

  logic [1:0]        state;
  owner_t            owner;
  logic              reqWe;
  logic [BE_W-1:0]   reqBe;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              protoErr;
  logic              respValid;
  logic              arbEn;
  logic              grantIf;
  logic              grantD;

  // A response only counts in WAIT; reset kills it even in that cycle.
  always_comb begin
    respValid = !rst && (state == ST_WAIT) && m_rvalid;
    arbEn     = !rst && ((state == ST_IDLE) || respValid);
  end

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) uPrio (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .arbEn    (arbEn),
    .grant_if (grantIf),
    .grant_d  (grantD)
  );

  // Sequencer: latch the winner's request, hold it through ISSUE, free the bus on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      reqWe    <= 1'b0;
      reqBe    <= '0;
      reqAddr  <= '0;
      reqWdata <= '0;
      protoErr <= 1'b0;
    end else begin
      if (m_rvalid && (state != ST_WAIT)) begin
        protoErr <= 1'b1;
      end
      if (grantD) begin
        state    <= ST_ISSUE;
        owner    <= OWN_DATA;
        reqWe    <= d_we;
        reqBe    <= d_be;
        reqAddr  <= d_addr;
        reqWdata <= d_wdata;
      end else if (grantIf) begin
        state    <= ST_ISSUE;
        owner    <= OWN_FETCH;
        reqWe    <= 1'b0;
        reqBe    <= {BE_W{1'b1}};
        reqAddr  <= if_addr;
        reqWdata <= '0;
      end else if ((state == ST_ISSUE) && m_gnt) begin
        state <= ST_WAIT;
      end else if (respValid) begin
        state <= ST_IDLE;
        owner <= OWN_NONE;
      end
    end
  end

  // Port-facing outputs; read data is only passed through alongside its rvalid.
  always_comb begin
    if_gnt    = grantIf;
    d_gnt     = grantD;
    if_rvalid = respValid && (owner == OWN_FETCH);
    d_rvalid  = respValid && (owner == OWN_DATA);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;
    m_req     = !rst && (state == ST_ISSUE);
    m_we      = reqWe;
    m_be      = reqBe;
    m_addr    = reqAddr;
    m_wdata   = reqWdata;
    busy      = !rst && (state != ST_IDLE);
    proto_err = protoErr;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled 2 ns after it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;
  logic        proto_err;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    nextCycle();
    if_req = 1'b1; d_req = 1'b1;
    #1;
    nTests++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      nFail++; $display("FAIL reset_gnt_blocked: got %b want 00", {if_gnt, d_gnt});
    end
    nextCycle();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    nTests++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy, proto_err} !== 8'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b want 00000000",
                        {if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy, proto_err});
    end
    nTests++;
    if ({m_addr, m_wdata, m_be, if_rdata, d_rdata} !== 132'b0) begin
      nFail++; $display("FAIL reset_data: got addr=%h wdata=%h be=%h ir=%h dr=%h want all 0",
                        m_addr, m_wdata, m_be, if_rdata, d_rdata);
    end
    nextCycle();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    #1;
    nTests++;
    if ({if_gnt, d_gnt, busy} !== 3'b100) begin
      nFail++; $display("FAIL fetch_gnt: got gnt_if/gnt_d/busy=%b want 100", {if_gnt, d_gnt, busy});
    end
    nextCycle();
    if_req = 1'b0; if_addr = 32'hFFFF_FFF0;
    #1;
    nTests++;
    if ({m_req, m_we, m_be, busy} !== 7'b1011111 || m_addr !== 32'h10) begin
      nFail++; $display("FAIL fetch_issue_c1: got req/we/be/busy=%b addr=%h want 1011111 addr=00000010",
                        {m_req, m_we, m_be, busy}, m_addr);
    end
    nextCycle();
    #1;
    nTests++;
    if (m_req !== 1'b1 || m_addr !== 32'h10) begin
      nFail++; $display("FAIL fetch_issue_c2: got req=%b addr=%h want 1 00000010", m_req, m_addr);
    end
    nextCycle();
    m_gnt = 1'b1;
    #1;
    nTests++;
    if (m_req !== 1'b1 || m_addr !== 32'h10) begin
      nFail++; $display("FAIL fetch_issue_c3: got req=%b addr=%h want 1 00000010", m_req, m_addr);
    end
    nextCycle();
    m_gnt = 1'b0;
    #1;
    nTests++;
    if ({m_req, busy, if_rvalid, d_rvalid} !== 4'b0100) begin
      nFail++; $display("FAIL fetch_wait: got req/busy/irv/drv=%b want 0100", {m_req, busy, if_rvalid, d_rvalid});
    end
    nextCycle();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
    #1;
    nTests++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'hCAFE_0001) begin
      nFail++; $display("FAIL fetch_resp: got irv=%b drv=%b rdata=%h want 1 0 cafe0001",
                        if_rvalid, d_rvalid, if_rdata);
    end
    nextCycle();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    nTests++;
    if ({busy, if_rvalid} !== 2'b00) begin
      nFail++; $display("FAIL fetch_done: got busy/irv=%b want 00", {busy, if_rvalid});
    end
    nextCycle();
  endtask

  task automatic test_store_vs_fetch();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #1;
    nTests++;
    if ({d_gnt, if_gnt} !== 2'b10) begin
      nFail++; $display("FAIL prio_data_first: got d/if gnt=%b want 10", {d_gnt, if_gnt});
    end
    nextCycle();
    d_req = 1'b0; d_wdata = 32'h0; d_be = 4'h0;
    m_gnt = 1'b1;
    #1;
    nTests++;
    if ({m_req, m_we, m_be, if_gnt} !== 7'b1100110 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h100) begin
      nFail++; $display("FAIL store_issue: got req/we/be/ifgnt=%b wdata=%h addr=%h want 1100110 deadbeef 00000100",
                        {m_req, m_we, m_be, if_gnt}, m_wdata, m_addr);
    end
    nextCycle();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
    #1;
    nTests++;
    if ({d_rvalid, if_rvalid, if_gnt, d_gnt} !== 4'b1010) begin
      nFail++; $display("FAIL store_ack_rearb: got drv/irv/ifgnt/dgnt=%b want 1010",
                        {d_rvalid, if_rvalid, if_gnt, d_gnt});
    end
    nextCycle();
    m_rvalid = 1'b0; if_req = 1'b0; m_gnt = 1'b1;
    #1;
    nTests++;
    if ({m_req, m_we, m_be} !== 6'b101111 || m_addr !== 32'h20 || m_wdata !== 32'h0) begin
      nFail++; $display("FAIL fetch_after_store: got req/we/be=%b addr=%h wdata=%h want 101111 00000020 00000000",
                        {m_req, m_we, m_be}, m_addr, m_wdata);
    end
    nextCycle();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    nTests++;
    if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'h1234_5678) begin
      nFail++; $display("FAIL fetch_after_store_resp: got irv=%b drv=%b rdata=%h want 1 0 12345678",
                        if_rvalid, d_rvalid, if_rdata);
    end
    nextCycle();
    clearInputs();
    #1;
    nTests++;
    if (busy !== 1'b0) begin
      nFail++; $display("FAIL store_fetch_idle: got busy=%b want 0", busy);
    end
    nextCycle();
  endtask

  task automatic test_starvation();
    string got = "";
    string exp = "";
    byte   ownQ[$];
    logic  accPrev = 1'b0;
    int    nGrants = 0;
    int    badRoute = 0;
    int    dualGnt = 0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    for (int c = 0; c < 60; c++) begin
      if (nGrants == 15) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      m_gnt = m_req; m_rvalid = accPrev; m_rdata = 32'h7000_0000 + c; accPrev = m_req;
      #1;
      if (if_rvalid) begin
        if (ownQ.size() == 0 || ownQ[0] != "F") badRoute++;
        if (ownQ.size() != 0) void'(ownQ.pop_front());
      end
      if (d_rvalid) begin
        if (ownQ.size() == 0 || ownQ[0] != "D") badRoute++;
        if (ownQ.size() != 0) void'(ownQ.pop_front());
      end
      if (if_gnt && d_gnt) dualGnt++;
      if (d_gnt) begin
        got = {got, "D"}; nGrants++; ownQ.push_back("D");
      end else if (if_gnt) begin
        got = {got, "F"}; nGrants++; ownQ.push_back("F");
      end
      nextCycle();
      if (nGrants == 15 && !busy && ownQ.size() == 0) break;
    end
    for (int k = 0; k < 15; k++) exp = {exp, ((k % 5) == 4) ? "F" : "D"};
    nTests++;
    if (got != exp) begin
      nFail++; $display("FAIL starve_pattern: got %s want %s", got, exp);
    end
    nTests++;
    if (badRoute != 0 || dualGnt != 0 || ownQ.size() != 0) begin
      nFail++; $display("FAIL starve_routing: got misroutes=%0d dual=%0d left=%0d want 0 0 0",
                        badRoute, dualGnt, ownQ.size());
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_back_to_back();
    int   rsp[$];
    logic accPrev = 1'b0;
    logic gntPrev = 1'b0;
    int   gntCount = 0;
    int   issueIdx = 0;
    int   badAddr = 0;
    int   badData = 0;
    int   busyDrops = 0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
    for (int c = 0; c < 10; c++) begin
      if (gntPrev) begin
        d_addr = d_addr + 32'h4;
        if (gntCount == 3) d_req = 1'b0;
      end
      m_gnt = m_req; m_rvalid = accPrev; m_rdata = 32'h5000_0000 + c; accPrev = m_req;
      #1;
      if (m_req) begin
        if (m_addr !== 32'h200 + 32'(issueIdx * 4) || m_we !== 1'b0) badAddr++;
        issueIdx++;
      end
      if (d_rvalid) begin
        rsp.push_back(c);
        if (d_rdata !== 32'h5000_0000 + c) badData++;
      end
      if (if_rvalid || if_gnt) badData++;
      if (c >= 1 && c <= 6 && busy !== 1'b1) busyDrops++;
      if (c == 7 && busy !== 1'b0) busyDrops++;
      gntPrev = d_gnt;
      if (d_gnt) gntCount++;
      nextCycle();
    end
    nTests++;
    if (rsp.size() != 3 || rsp[0] != 2 || rsp[1] != 4 || rsp[2] != 6) begin
      nFail++; $display("FAIL b2b_resp_cycles: got %0d responses first at %0d want 3 at 2,4,6",
                        rsp.size(), (rsp.size() != 0) ? rsp[0] : -1);
    end
    nTests++;
    if (badAddr != 0 || badData != 0 || issueIdx != 3 || gntCount != 3) begin
      nFail++; $display("FAIL b2b_fields: got badAddr=%0d badData=%0d issues=%0d gnts=%0d want 0 0 3 3",
                        badAddr, badData, issueIdx, gntCount);
    end
    nTests++;
    if (busyDrops != 0) begin
      nFail++; $display("FAIL b2b_busy: got %0d busy glitches want 0", busyDrops);
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_reset_mid_wait();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
    #1;
    nTests++;
    if (d_gnt !== 1'b1) begin
      nFail++; $display("FAIL rstwait_gnt: got %b want 1", d_gnt);
    end
    nextCycle();
    d_req = 1'b0; m_gnt = 1'b1;
    nextCycle();
    m_gnt = 1'b0; rst = 1'b1;
    nextCycle();
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0001;
    #1;
    nTests++;
    if ({if_rvalid, d_rvalid, busy, m_req, if_gnt, d_gnt, proto_err} !== 7'b0) begin
      nFail++; $display("FAIL rstwait_ctrl: got irv/drv/busy/mreq/ignt/dgnt/perr=%b want 0000000",
                        {if_rvalid, d_rvalid, busy, m_req, if_gnt, d_gnt, proto_err});
    end
    nTests++;
    if ({m_we, m_be, m_addr, m_wdata, if_rdata, d_rdata} !== 133'b0) begin
      nFail++; $display("FAIL rstwait_data: got be=%h addr=%h wdata=%h ir=%h dr=%h want all 0",
                        m_be, m_addr, m_wdata, if_rdata, d_rdata);
    end
    nextCycle();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    nTests++;
    if (proto_err !== 1'b1) begin
      nFail++; $display("FAIL rstwait_late_rvalid_err: got %b want 1", proto_err);
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    d_req = 1'b1; d_addr = 32'h304;
    #1;
    nTests++;
    if (proto_err !== 1'b0 || d_gnt !== 1'b1) begin
      nFail++; $display("FAIL rst_clears_err: got perr=%b dgnt=%b want 0 1", proto_err, d_gnt);
    end
    nextCycle();
    d_req = 1'b0; m_gnt = 1'b1;
    nextCycle();
    m_gnt = 1'b0; rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0002;
    #1;
    nTests++;
    if ({if_rvalid, d_rvalid, d_rdata} !== 34'b0) begin
      nFail++; $display("FAIL rst_same_cycle_resp: got irv=%b drv=%b dr=%h want 0 0 0",
                        if_rvalid, d_rvalid, d_rdata);
    end
    nextCycle();
    rst = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    #1;
    nTests++;
    if ({proto_err, busy} !== 2'b00) begin
      nFail++; $display("FAIL rst_same_cycle_err: got perr/busy=%b want 00", {proto_err, busy});
    end
    nextCycle();
  endtask

  task automatic test_stray_rvalid();
    m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF; m_gnt = 1'b1;
    #1;
    nTests++;
    if ({if_rvalid, d_rvalid, busy, m_req, proto_err} !== 5'b0 || if_rdata !== 32'h0) begin
      nFail++; $display("FAIL stray_route: got irv/drv/busy/mreq/perr=%b ir=%h want 00000 0",
                        {if_rvalid, d_rvalid, busy, m_req, proto_err}, if_rdata);
    end
    nextCycle();
    m_rvalid = 1'b0; m_rdata = '0; m_gnt = 1'b0;
    #1;
    nTests++;
    if ({proto_err, busy} !== 2'b10) begin
      nFail++; $display("FAIL stray_sets_err: got perr/busy=%b want 10", {proto_err, busy});
    end
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      nTests++;
      if (proto_err !== 1'b1) begin
        nFail++; $display("FAIL stray_sticky[%0d]: got %b want 1", c, proto_err);
      end
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1;
    nTests++;
    if (proto_err !== 1'b0) begin
      nFail++; $display("FAIL stray_cleared: got %b want 0", proto_err);
    end
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_vs_fetch();
    test_starvation();
    test_back_to_back();
    test_reset_mid_wait();
    test_stray_rvalid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
